sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
Parametrised multi-channel burst scheduler between the per-channel write/read FIFOs and the SDRAM command engine. It generalises the single write port and single read port, each with a start address, max address and load, to NCH independent channels. Each channel has a configurable direction and its own wrapping address window. The block decides which channel gets the next SDRAM burst, drives the burst address, and advances the channel pointer when the burst completes.

Parameters:
NCH, 4, number of channels (2..8)
AW, 24, SDRAM linear word address width
LW, 10, FIFO level width per channel
BURST_LEN, 8, words per burst (power of 2)
FIFO_DEPTH, 512, FIFO depth in words, used for read-space check
WR_MASK, 4'b0011, bit i=1 means channel i is a write channel (FIFO to SDRAM); bit i=0 means a read channel (SDRAM to FIFO)

Ports:
Clk  in  1  system clock, 100 MHz domain
Rst  in  1  synchronous active-high reset
Init_done  in  1  SDRAM initialisation complete; no request is issued while low
Ch_en  in  NCH  per-channel enable
Ch_load  in  NCH  per-channel pulse that reloads the pointer to its base
Ch_base  in  NCH*AW  per-channel start address, channel i at [i*AW +: AW]
Ch_max  in  NCH*AW  per-channel last valid address (inclusive)
Ch_level  in  NCH*LW  FIFO fill level in the Clk domain
Burst_req  out  1  burst request to the command engine
Burst_wr  out  1  1 = write burst, 0 = read burst; valid while Burst_req is high
Burst_addr  out  AW  burst start address
Burst_ack  in  1  command engine accepted the request
Burst_done  in  1  one-cycle pulse when the last word of the burst has been transferred
Ch_grant  out  NCH  one-hot grant that steers the FIFO data path; held from the REQ state until done
Busy  out  1  FSM not in IDLE

Behaviour:
- Reset (Rst=1 at a Clk edge):
  - FSM goes to IDLE.
  - Burst_req=0, Burst_wr=0, Burst_addr=0, Ch_grant=0, Busy=0.
  - RR priority pointer is set to 0.
  - Every channel pointer ptr[i] is set to Ch_base[i].
  - Reset during a burst abandons it; a Burst_done arriving after reset is ignored.
- Eligibility (combinational, per channel i), with Ch_en[i]=1 required in both cases:
  - Write channel: Ch_level[i] >= BURST_LEN.
  - Read channel: Ch_level[i] <= FIFO_DEPTH-BURST_LEN.
- Round-robin selection: the first eligible channel searching upward from the priority pointer, modulo NCH. After a grant to channel k, the priority pointer becomes (k+1) mod NCH.
- FSM states:
  - IDLE: if Init_done and any channel is eligible, latch the selected k. Set Burst_addr=ptr[k], Burst_wr=WR_MASK[k], Ch_grant=1<<k, Burst_req=1, and go to REQ. Burst_req therefore rises one cycle after eligibility is sampled.
  - REQ: hold Burst_req, Burst_addr, Burst_wr and Ch_grant stable until Burst_ack. On Burst_ack, drop Burst_req in the next cycle and go to RUN.
  - RUN: wait for Burst_done. On Burst_done, advance ptr[k], clear Ch_grant, rotate the priority pointer, and go to IDLE. A new grant is possible on the next cycle.
  - Burst_done seen in REQ together with Burst_ack counts as both events: go directly to IDLE.
- Pointer advance (computed with AW+1 bits):
  - nxt = ptr+BURST_LEN.
  - If nxt+BURST_LEN-1 > Ch_max, nxt = Ch_base. A burst never crosses Ch_max.
- Ch_load[i]:
  - Sets ptr[i]=Ch_base[i] on the next edge in any state.
  - If channel i is mid-burst, the burst continues at its latched address, and the advance at Burst_done is suppressed (load wins).
  - Load and done for the same channel in the same cycle: the result is base.
- Ch_en deasserted mid-burst does not abort the burst; it only affects future eligibility.
- Init_done low mid-burst: the current burst completes; no new request is issued.
- Ch_base/Ch_max are quasi-static and are changed only together with Ch_load. Ch_max < Ch_base+BURST_LEN-1 is illegal.

Test Plan:
- Single write channel: BURST_LEN=8, base=0, max=1000, level=8, ack 2 cycles after req, done 10 cycles later. Required: Burst_addr sequence 0,8,...,984,992, then 0. Burst_wr=1 throughout. Burst_req rises exactly 1 cycle after the level reaches 8.
- All 4 channels eligible continuously: grants rotate 0,1,2,3,0. Burst_wr matches WR_MASK=0011. Each channel's address advances only on its own grant.
- Read channel 2 with level 505 (>504) gets no grant. When the level drops to 504, it is granted on the next cycle with Burst_wr=0.
- Ch_load[0] pulsed while channel 0 is in RUN with ptr=40: the burst completes at 40, then the next channel-0 burst is at base 0 (not 48).
- Rst asserted in RUN: the next cycle shows all outputs 0 and Busy=0. A following Burst_done is ignored, and all pointers equal their bases.
- Init_done=0 with all channels eligible: Burst_req stays 0 for 100 cycles. After Init_done rises, the first grant goes to channel 0.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// Bus between the multi-channel burst arbiter and its surroundings:
// per-channel FIFO status and configuration in, burst command out.
//
// Handshake: burst_req is the valid of a burst command. burst_addr,
// burst_wr and ch_grant are stable while burst_req is high. burst_ack
// is the ready. The command is taken on the rising clock edge where both
// are high. After that edge burst_req is low until a later command is
// issued. burst_done is a one-cycle pulse that closes the accepted burst.
interface sdram_port_arbiter_if #(
  parameter int NCH = 4,
  parameter int AW  = 24,
  parameter int LW  = 10
);
  logic                init_done;
  logic [NCH-1:0]      ch_en;
  logic [NCH-1:0]      ch_load;
  logic [NCH*AW-1:0]   ch_base;
  logic [NCH*AW-1:0]   ch_max;
  logic [NCH*LW-1:0]   ch_level;
  logic                burst_req;
  logic                burst_wr;
  logic [AW-1:0]       burst_addr;
  logic                burst_ack;
  logic                burst_done;
  logic [NCH-1:0]      ch_grant;
  logic                busy;

  // Arbiter side
  modport slave (
    input  init_done, ch_en, ch_load, ch_base, ch_max, ch_level,
    input  burst_ack, burst_done,
    output burst_req, burst_wr, burst_addr, ch_grant, busy
  );

  // Command engine / FIFO side
  modport master (
    output init_done, ch_en, ch_load, ch_base, ch_max, ch_level,
    output burst_ack, burst_done,
    input  burst_req, burst_wr, burst_addr, ch_grant, busy
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin burst scheduler for NCH SDRAM channels. Each channel has a
// direction, a wrapping address window [base, max] and a FIFO level.
// One burst is in flight at a time. The channel pointer advances by
// BURST_LEN when its burst completes, and wraps so a burst never crosses max.
module sdram_port_arbiter #(
  parameter int             NCH        = 4,
  parameter int             AW         = 24,
  parameter int             LW         = 10,
  parameter int             BURST_LEN  = 8,
  parameter int             FIFO_DEPTH = 512,
  parameter logic [NCH-1:0] WR_MASK    = NCH'(4'b0011)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  sdram_port_arbiter_if.slave bus,
  output logic [1:0]          o_dbg_state
);

  localparam int            PW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [LW-1:0] L_WR_TH = LW'(BURST_LEN);
  localparam logic [LW-1:0] L_RD_TH = LW'(FIFO_DEPTH - BURST_LEN);
  localparam logic [AW:0]   L_BL    = (AW+1)'(BURST_LEN);
  localparam logic [AW:0]   L_BL_M1 = (AW+1)'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [AW-1:0]  r_ptr [NCH];
  logic [PW-1:0]  r_rr;
  logic [PW-1:0]  r_sel;
  logic           r_req;
  logic           r_wr;
  logic [AW-1:0]  r_addr;
  logic [NCH-1:0] r_grant;
  // Set when the granted channel was reloaded during its burst; the
  // completion then must not advance the freshly reloaded pointer.
  logic           r_load_seen;

  logic [NCH-1:0] w_elig;
  logic           w_any;
  logic [PW-1:0]  w_pick;
  logic           w_start;
  logic           w_finish;
  logic [AW-1:0]  w_base_sel;
  logic [AW-1:0]  w_max_sel;
  logic [AW:0]    w_nxt;
  logic [AW-1:0]  w_adv;

  // Per-channel eligibility: enough data to write or enough space to read
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      if (WR_MASK[i]) begin
        w_elig[i] = bus.ch_en[i] && (bus.ch_level[i*LW +: LW] >= L_WR_TH);
      end else begin
        w_elig[i] = bus.ch_en[i] && (bus.ch_level[i*LW +: LW] <= L_RD_TH);
      end
    end
  end

  // Round-robin pick: first eligible channel at or above the priority pointer
  always_comb begin
    int j;
    w_any  = 1'b0;
    w_pick = '0;
    j      = 0;
    // Scan from the far end so the nearest eligible channel is written last
    for (int off = NCH - 1; off >= 0; off--) begin
      j = (int'(r_rr) + off) % NCH;
      if (w_elig[j]) begin
        w_any  = 1'b1;
        w_pick = PW'(j);
      end
    end
  end

  // Next-state logic and the start/finish strobes of a burst
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.init_done && w_any) begin
          w_state_nxt = ST_REQ;
          w_start     = 1'b1;
        end
      end
      ST_REQ: begin
        if (bus.burst_ack) begin
          if (bus.burst_done) begin
            w_state_nxt = ST_IDLE;
            w_finish    = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.burst_done) begin
          w_state_nxt = ST_IDLE;
          w_finish    = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pointer advance for the granted channel, wrapping before max is crossed
  always_comb begin
    w_base_sel = bus.ch_base[int'(r_sel)*AW +: AW];
    w_max_sel  = bus.ch_max[int'(r_sel)*AW +: AW];
    w_nxt      = {1'b0, r_addr} + L_BL;
    if ((w_nxt + L_BL_M1) > {1'b0, w_max_sel}) begin
      w_adv = w_base_sel;
    end else begin
      w_adv = w_nxt[AW-1:0];
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Burst command registers, grant and round-robin priority
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_req       <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_grant     <= '0;
      r_sel       <= '0;
      r_rr        <= '0;
      r_load_seen <= 1'b0;
    end else if (w_start) begin
      r_sel       <= w_pick;
      r_addr      <= r_ptr[w_pick];
      r_wr        <= WR_MASK[w_pick];
      r_grant     <= {{(NCH-1){1'b0}}, 1'b1} << w_pick;
      r_req       <= 1'b1;
      r_load_seen <= bus.ch_load[w_pick];
    end else begin
      if ((r_state == ST_REQ) && bus.burst_ack) begin
        r_req <= 1'b0;
      end
      if ((r_state != ST_IDLE) && bus.ch_load[r_sel]) begin
        r_load_seen <= 1'b1;
      end
      if (w_finish) begin
        r_grant <= '0;
        r_rr    <= (int'(r_sel) == NCH - 1) ? '0 : r_sel + 1'b1;
      end
    end
  end

  // Channel pointers: reload has priority over the completion advance
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (i_rst || bus.ch_load[i]) begin
        r_ptr[i] <= bus.ch_base[i*AW +: AW];
      end else if (w_finish && !r_load_seen && (int'(r_sel) == i)) begin
        r_ptr[i] <= w_adv;
      end
    end
  end

  assign bus.burst_req  = r_req;
  assign bus.burst_wr   = r_wr;
  assign bus.burst_addr = r_addr;
  assign bus.ch_grant   = r_grant;
  assign bus.busy       = (r_state != ST_IDLE);
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus randomized bursts,
// each granted burst compared against a transaction-level channel model.
module tb_sdram_port_arbiter;

  localparam int             NCH   = 4;
  localparam int             AW    = 24;
  localparam int             LW    = 10;
  localparam int             BL    = 8;
  localparam int             DEPTH = 512;
  localparam logic [NCH-1:0] WRM   = 4'b0011;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.NCH(NCH), .AW(AW), .LW(LW)) bus ();

  sdram_port_arbiter #(
    .NCH(NCH), .AW(AW), .LW(LW), .BURST_LEN(BL),
    .FIFO_DEPTH(DEPTH), .WR_MASK(WRM)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  // ---------------- bench state and model ----------------
  int             chk_cnt  = 0;
  int             fail_cnt = 0;
  int             t_base  [NCH];
  int             t_max   [NCH];
  int             t_level [NCH];
  logic [NCH-1:0] t_en;
  logic           t_init;
  logic [NCH-1:0] wr_mask_v = WRM;
  longint         m_ptr [NCH];
  int             m_rr;
  logic [AW-1:0]  exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    bus.init_done = t_init;
    bus.ch_en     = t_en;
    for (int i = 0; i < NCH; i++) begin
      bus.ch_base[i*AW +: AW]  = AW'(t_base[i]);
      bus.ch_max[i*AW +: AW]   = AW'(t_max[i]);
      bus.ch_level[i*LW +: LW] = LW'(t_level[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_ptr[i] = t_base[i];
    m_rr = 0;
    exp_q.delete();
  endtask

  // Which channel should win next, or -1 if no request is due
  function automatic int model_pick();
    int j;
    bit ok;
    if (!t_init) return -1;
    for (int off = 0; off < NCH; off++) begin
      j = (m_rr + off) % NCH;
      if (wr_mask_v[j]) ok = (t_level[j] >= BL);
      else              ok = (t_level[j] <= DEPTH - BL);
      if (t_en[j] && ok) return j;
    end
    return -1;
  endfunction

  // Burst on channel k completed; ld is the channel reloaded meanwhile (-1 none)
  task automatic model_done(input int k, input int ld);
    longint nxt;
    if (ld >= 0) m_ptr[ld] = t_base[ld];
    if (ld != k) begin
      nxt = m_ptr[k] + BL;
      if (nxt + BL - 1 > t_max[k]) nxt = t_base[k];
      m_ptr[k] = nxt;
    end
    m_rr = (k + 1) % NCH;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_req"},   bus.burst_req,  0);
    check_val({tag, "_wr"},    bus.burst_wr,   0);
    check_val({tag, "_addr"},  bus.burst_addr, 0);
    check_val({tag, "_grant"}, bus.ch_grant,   0);
    check_val({tag, "_busy"},  bus.busy,       0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.burst_ack  = 1'b0;
    bus.burst_done = 1'b0;
    bus.ch_load    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_idle_outputs("reset");
  endtask

  task automatic rand_inputs();
    t_init = ($urandom_range(0, 9) != 0);
    t_en   = NCH'($urandom_range(0, (1 << NCH) - 1));
    for (int i = 0; i < NCH; i++) begin
      case ($urandom_range(0, 3))
        0:       t_level[i] = $urandom_range(0, 1023);
        1:       t_level[i] = BL - 1 + $urandom_range(0, 1);
        2:       t_level[i] = DEPTH - BL - 1 + $urandom_range(0, 2);
        default: t_level[i] = $urandom_range(0, 16);
      endcase
    end
    drive();
  endtask

  // ---------------- driver: one complete burst ----------------
  // Called right after a negedge with the inputs for the next decision applied.
  task automatic do_burst(input int ack_dly, input int done_dly, input int ld_ch,
                          input int ld_at, input bit rnd_mid);
    int            k;
    int            waited;
    logic [AW-1:0] exp_a;
    k = model_pick();
    if (k < 0) begin
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        check_val("no_req", bus.burst_req, 0);
      end
      return;
    end
    exp_q.push_back(AW'(m_ptr[k]));
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.burst_req && waited < 50);
    check_val("req_latency", waited, 1);
    exp_a = exp_q.pop_front();
    if (!bus.burst_req) return;
    check_val("addr",  bus.burst_addr, exp_a);
    check_val("grant", bus.ch_grant,   32'(1) << k);
    check_val("wr",    bus.burst_wr,   wr_mask_v[k]);
    check_val("busy",  bus.busy,       1);
    for (int c = 0; c < ack_dly; c++) begin
      @(negedge clk);
      check_val("req_hold",  bus.burst_req,  1);
      check_val("addr_hold", bus.burst_addr, exp_a);
    end
    bus.burst_ack  = 1'b1;
    bus.burst_done = (done_dly == 0);
    @(negedge clk);
    bus.burst_ack  = 1'b0;
    bus.burst_done = 1'b0;
    check_val("req_drop", bus.burst_req, 0);
    if (done_dly == 0) begin
      check_val("ackdone_busy",  bus.busy,     0);
      check_val("ackdone_grant", bus.ch_grant, 0);
      model_done(k, -1);
      return;
    end
    check_val("grant_run", bus.ch_grant, 32'(1) << k);
    for (int c = 0; c < done_dly; c++) begin
      if (c == 0 && rnd_mid) begin
        t_init = ($urandom_range(0, 9) != 0);
        t_en   = NCH'($urandom_range(0, (1 << NCH) - 1));
        drive();
      end
      if (ld_ch >= 0 && c == ld_at) begin
        if (rnd_mid) begin
          t_base[ld_ch] = $urandom_range(0, 3000);
          t_max[ld_ch]  = t_base[ld_ch] + BL - 1 + $urandom_range(0, 40);
          drive();
        end
        bus.ch_load = NCH'(1) << ld_ch;
      end else begin
        bus.ch_load = '0;
      end
      bus.burst_done = (c == done_dly - 1);
      @(negedge clk);
      if (c < done_dly - 1) check_val("grant_hold", bus.ch_grant, 32'(1) << k);
    end
    bus.ch_load    = '0;
    bus.burst_done = 1'b0;
    check_val("done_grant", bus.ch_grant, 0);
    check_val("done_busy",  bus.busy,     0);
    model_done(k, ld_ch);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ld;
    int dd;
    int waited;
    bus.burst_ack  = 1'b0;
    bus.burst_done = 1'b0;
    bus.ch_load    = '0;
    t_init = 1'b1;
    t_en   = '0;
    for (int i = 0; i < NCH; i++) begin
      t_base[i]  = i * 4096;
      t_max[i]   = t_base[i] + ((i == 0) ? 1000 : 200);
      t_level[i] = 0;
    end
    drive();
    do_reset();

    // Single write channel: 0,8,...,992 then wrap to 0
    t_en = 4'b0001;
    t_level[0] = 8;
    drive();
    for (int n = 0; n < 126; n++) do_burst(2, 10, -1, 0, 1'b0);

    // All channels eligible: rotation 0,1,2,3,0,...
    do_reset();
    t_en = 4'b1111;
    t_level[0] = 100; t_level[1] = 100; t_level[2] = 0; t_level[3] = 0;
    drive();
    for (int n = 0; n < 9; n++) do_burst(n % 3, 1 + (n % 4), -1, 0, 1'b0);

    // Read channel 2 threshold: 505 blocked, 504 granted
    t_en = 4'b0100;
    t_level[2] = 505;
    drive();
    do_burst(1, 3, -1, 0, 1'b0);
    t_level[2] = 504;
    drive();
    do_burst(1, 3, -1, 0, 1'b0);

    // Reload of channel 0 while its burst at 40 is running
    do_reset();
    t_en = 4'b0001;
    t_level[0] = 8;
    drive();
    for (int n = 0; n < 5; n++) do_burst(1, 4, -1, 0, 1'b0);
    do_burst(1, 6, 0, 2, 1'b0);
    do_burst(1, 4, -1, 0, 1'b0);

    // Reset while a burst runs; a late done must be ignored
    t_en = 4'b0010;
    t_level[1] = 100;
    drive();
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.burst_req && waited < 50);
    check_val("rstrun_req", bus.burst_req, 1);
    bus.burst_ack = 1'b1;
    @(negedge clk);
    bus.burst_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    t_en = '0;
    drive();
    check_idle_outputs("rstrun");
    bus.burst_done = 1'b1;
    @(negedge clk);
    bus.burst_done = 1'b0;
    check_val("late_done_busy", bus.busy,      0);
    check_val("late_done_req",  bus.burst_req, 0);
    model_reset();
    t_en = 4'b1111;
    t_level[0] = 100; t_level[1] = 100; t_level[2] = 0; t_level[3] = 0;
    drive();
    for (int n = 0; n < 4; n++) do_burst(0, 2, -1, 0, 1'b0);

    // Init_done low holds off all requests
    do_reset();
    t_init = 1'b0;
    drive();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check_val("init_low_req", bus.burst_req, 0);
    end
    t_init = 1'b1;
    drive();
    do_burst(1, 2, -1, 0, 1'b0);

    // Randomized traffic with reloads, window changes and mid-burst input changes
    do_reset();
    for (int n = 0; n < 250; n++) begin
      rand_inputs();
      dd = $urandom_range(0, 6);
      ld = ($urandom_range(0, 3) == 0 && dd > 0) ? $urandom_range(0, NCH - 1) : -1;
      do_burst($urandom_range(0, 3), dd, ld, (dd > 0) ? $urandom_range(0, dd - 1) : 0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
